// File: rtl/lzd_norm_arb.sv
// lzd_norm_arb: two-requester round-robin front end for the shared 48-bit
// leading-zero detector. Samples flow through an issue stage (S1, drives the
// LZD), an align stage (S2, meets the registered zero count), a combinational
// left-normaliser, and a 4-entry result FIFO tagged with the requester id.
// Acceptance is credit based so S1/S2 never stall and the FIFO never overflows.

module lzd_norm_arb (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        scan_in0,
    input  logic        scan_en,
    input  logic        test_mode,
    output logic        scan_out0,

    input  logic        req0_valid,
    input  logic [47:0] req0_data,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [47:0] req1_data,
    output logic        req1_ready,

    output logic [47:0] lzd_din,
    input  logic [5:0]  lzd_numz,
    output logic        lzd_reset,

    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_tag,
    output logic [5:0]  out_numz,
    output logic [47:0] out_mant,
    output logic        out_zero
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        req_id_t     tag;
        logic        zero;
        logic [5:0]  numz;
        logic [47:0] mant;
    } fifo_ent_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_v1;
    logic [47:0] r_d1;
    req_id_t     r_t1;

    logic        r_v2;
    logic [47:0] r_d2;
    req_id_t     r_t2;

    req_id_t     r_last_grant;

    fifo_ent_t   r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_cnt;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [3:0]  w_inflight;
    logic        w_credit_ok;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic [47:0] w_sel_data;
    req_id_t     w_sel_tag;

    logic        w_numz_bad;
    fifo_ent_t   w_norm;

    logic        w_push;
    logic        w_pop;
    fifo_ent_t   w_head;

    logic        w_unused_scan;

    // Scan hooks are placeholders until scan insertion.
    assign scan_out0     = 1'b0;
    assign w_unused_scan = ^{scan_in0, scan_en, test_mode};

    // The LZD macro uses an active-high reset.
    assign lzd_reset = ~reset_n;

    // Everything already committed downstream (FIFO + both pipeline stages)
    // counts against the 4 FIFO slots, so a granted sample always has room.
    assign w_inflight  = {1'b0, r_cnt} + {3'b000, r_v1} + {3'b000, r_v2};
    assign w_credit_ok = (w_inflight < 4'd4);

    // Round-robin grant: single requester wins outright, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_credit_ok) begin
            if (req0_valid && req1_valid) begin
                if (r_last_grant == REQ1) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (req0_valid) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // Readies are forced low while reset is held so no handshake can occur.
    assign req0_ready = w_gnt0 & reset_n;
    assign req1_ready = w_gnt1 & reset_n;

    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_sel_data = w_gnt1 ? req1_data : req0_data;
    assign w_sel_tag  = w_gnt1 ? REQ1 : REQ0;

    // S1 issue register; data holds when nothing is granted so lzd_din stays quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1         <= 1'b0;
            r_d1         <= '0;
            r_t1         <= REQ0;
            r_last_grant <= REQ1;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_d1         <= w_sel_data;
                r_t1         <= w_sel_tag;
                r_last_grant <= w_sel_tag;
            end
        end
    end

    assign lzd_din = r_d1;

    // S2 align register: lines up with the LZD's registered zero count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
            r_t2 <= REQ0;
        end else begin
            r_v2 <= r_v1;
            r_d2 <= r_d1;
            r_t2 <= r_t1;
        end
    end

    // Left-normalise S2 data; an out-of-range count is treated as a zero
    // sample (count saturated to 48) so nothing garbled reaches the evaluators.
    always_comb begin
        w_numz_bad  = (lzd_numz > 6'd48);
        w_norm      = '0;
        w_norm.tag  = r_t2;
        if (w_numz_bad) begin
            w_norm.numz = 6'd48;
            w_norm.mant = '0;
            w_norm.zero = 1'b1;
        end else begin
            w_norm.numz = lzd_numz;
            w_norm.mant = r_d2 << lzd_numz;
            w_norm.zero = (lzd_numz == 6'd48);
        end
    end

    assign w_push = r_v2;
    assign w_pop  = out_ready & (r_cnt != 3'd0);

    // Result FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_norm;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_cnt != 3'd0);
    assign out_tag   = w_head.tag;
    assign out_numz  = w_head.numz;
    assign out_mant  = w_head.mant;
    assign out_zero  = w_head.zero;

    a_numz_legal: assert property (@(posedge clk) disable iff (!reset_n)
        r_v2 |-> (lzd_numz <= 6'd48));

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (w_push && !w_pop) |-> (r_cnt < 3'd4));

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        !(req0_ready && req1_ready));

endmodule

// File: tb/tb_lzd_norm_arb.sv
// Directed and randomised bench for lzd_norm_arb with a behavioural LZD
// (registered count of the issue register) and an in-order result scoreboard.

module tb_lzd_norm_arb;

    logic        clk;
    logic        reset_n;
    logic        scan_in0, scan_en, test_mode, scan_out0;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [47:0] req0_data, req1_data;
    logic [47:0] lzd_din;
    logic [5:0]  lzd_numz;
    logic        lzd_reset;
    logic        out_valid, out_ready, out_tag, out_zero;
    logic [5:0]  out_numz;
    logic [47:0] out_mant;

    typedef struct packed {
        logic        tag;
        logic        zero;
        logic [5:0]  numz;
        logic [47:0] mant;
    } ent_t;

    ent_t exp_q[$];
    int   checks;
    int   errors;
    int   hs_count;
    bit   auto_exp;

    lzd_norm_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_in0   (scan_in0),
        .scan_en    (scan_en),
        .test_mode  (test_mode),
        .scan_out0  (scan_out0),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lzd_din    (lzd_din),
        .lzd_numz   (lzd_numz),
        .lzd_reset  (lzd_reset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_numz   (out_numz),
        .out_mant   (out_mant),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lzc(input logic [47:0] d);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (d[i]) n = 6'(47 - i);
        end
        return n;
    endfunction

    // Behavioural LZD: count registered one cycle after lzd_din.
    always @(posedge clk or posedge lzd_reset) begin
        if (lzd_reset) lzd_numz <= 6'd48;
        else           lzd_numz <= lzc(lzd_din);
    end

    function automatic ent_t ref_ent(input logic tag, input logic [47:0] d);
        ent_t e;
        e.tag  = tag;
        e.numz = lzc(d);
        e.zero = (e.numz == 6'd48);
        e.mant = e.zero ? 48'h0 : (d << e.numz);
        return e;
    endfunction

    function automatic ent_t mk(input logic tag, input logic zero,
                                input logic [5:0] numz, input logic [47:0] mant);
        ent_t e;
        e.tag = tag; e.zero = zero; e.numz = numz; e.mant = mant;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One clock with scoreboard bookkeeping; caller drives inputs beforehand.
    task automatic step();
        ent_t e;
        #1;
        chk("ready_onehot", {63'b0, req0_ready & req1_ready}, 64'd0);
        if (auto_exp) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back(ref_ent(1'b0, req0_data));
                hs_count++;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back(ref_ent(1'b1, req1_data));
                hs_count++;
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_spurious_pop", {63'b0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_tag",  {63'b0, out_tag},  {63'b0, e.tag});
                chk("sb_numz", {58'b0, out_numz}, {58'b0, e.numz});
                chk("sb_mant", {16'b0, out_mant}, {16'b0, e.mant});
                chk("sb_zero", {63'b0, out_zero}, {63'b0, e.zero});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        exp_q.delete();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [47:0] rnd_sample();
        logic [63:0] r;
        logic [47:0] d;
        r = {$urandom(), $urandom()};
        d = r[47:0];
        return d >> $urandom_range(0, 48);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        checks = 0; errors = 0; hs_count = 0; auto_exp = 1'b0;
        scan_in0 = 1'b0; scan_en = 1'b0; test_mode = 1'b0;
        req0_data = '0; req1_data = '0; out_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        // Reset state
        chk("rst_ready0",    req0_ready, 0);
        chk("rst_ready1",    req1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag",   out_tag, 0);
        chk("rst_out_numz",  out_numz, 0);
        chk("rst_out_mant",  out_mant, 0);
        chk("rst_out_zero",  out_zero, 0);
        chk("rst_lzd_din",   lzd_din, 0);
        chk("rst_lzd_reset", lzd_reset, 1);
        chk("rst_scan_out",  scan_out0, 0);
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset_n = 1'b1;
        #1 chk("rel_lzd_reset", lzd_reset, 0);
        @(posedge clk); #1;

        // Single req0 sample 1: three-cycle latency
        req0_valid = 1'b1; req0_data = 48'h0000_0000_0001; out_ready = 1'b1;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("t1_lzd_din", lzd_din, 48'h0000_0000_0001);
        chk("t1_valid_k", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid_k1", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid_k2", out_valid, 1);
        chk("t1_tag",  out_tag, 0);
        chk("t1_numz", out_numz, 47);
        chk("t1_mant", out_mant, 48'h8000_0000_0000);
        chk("t1_zero", out_zero, 0);
        @(posedge clk); #1;
        chk("t1_popped", out_valid, 0);
        chk("t1_lzd_din_hold", lzd_din, 48'h0000_0000_0001);

        // Both valid continuously: alternating grants, full throughput
        do_reset();
        out_ready = 1'b1; req0_data = 48'h0; req1_data = 48'hFFFF_FFFF_FFFF;
        for (int j = 0; j < 9; j++) begin
            req0_valid = (j < 6);
            req1_valid = (j < 6);
            #1;
            if (j < 6) begin
                chk("t2_ready0", req0_ready, (j % 2) == 0);
                chk("t2_ready1", req1_ready, (j % 2) == 1);
            end
            if (j >= 3) begin
                chk("t2_valid", out_valid, 1);
                if (((j - 3) % 2) == 0) begin
                    chk("t2_tag0",  out_tag, 0);
                    chk("t2_numz0", out_numz, 48);
                    chk("t2_mant0", out_mant, 48'h0);
                    chk("t2_zero0", out_zero, 1);
                end else begin
                    chk("t2_tag1",  out_tag, 1);
                    chk("t2_numz1", out_numz, 0);
                    chk("t2_mant1", out_mant, 48'hFFFF_FFFF_FFFF);
                    chk("t2_zero1", out_zero, 0);
                end
            end else begin
                chk("t2_valid_lat", out_valid, 0);
            end
            @(posedge clk); #1;
        end

        // Backpressure: exactly four accepted, then drain and resume
        do_reset();
        out_ready = 1'b0;
        req0_data = 48'h0000_0000_00F0;
        req1_data = 48'h0000_1234_5678;
        for (int j = 0; j < 8; j++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            chk("t3_ready0", req0_ready, (j == 0) || (j == 2));
            chk("t3_ready1", req1_ready, (j == 1) || (j == 3));
            if (j >= 3) begin
                chk("t3_hold_valid", out_valid, 1);
                chk("t3_hold_tag",   out_tag, 0);
                chk("t3_hold_numz",  out_numz, 40);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int d = 0; d < 6; d++) begin
            #1;
            if (d == 0) begin
                chk("t3_full_ready0", req0_ready, 0);
                chk("t3_full_ready1", req1_ready, 0);
            end
            if (d == 1) begin
                chk("t3_resume_ready0", req0_ready, 1);
                chk("t3_resume_ready1", req1_ready, 0);
            end
            if (d < 5) begin
                chk("t3_drain_valid", out_valid, 1);
                chk("t3_drain_tag",   out_tag, d % 2);
                chk("t3_drain_numz",  out_numz, (d % 2) ? 19 : 40);
                chk("t3_drain_mant",  out_mant,
                    (d % 2) ? 48'h91A2_B3C0_0000 : 48'hF000_0000_0000);
                chk("t3_drain_zero",  out_zero, 0);
            end else begin
                chk("t3_drain_empty", out_valid, 0);
            end
            @(posedge clk); #1;
            if (d == 1) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end

        // Push and pop together at count 3
        do_reset();
        auto_exp = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b0, 6'd0,  48'h8000_0000_0000));
        exp_q.push_back(mk(1'b1, 1'b0, 6'd46, 48'h8000_0000_0000));
        exp_q.push_back(mk(1'b1, 1'b0, 6'd15, 48'h8000_0000_0000));
        exp_q.push_back(mk(1'b1, 1'b0, 6'd4,  48'hF000_0000_0030));
        exp_q.push_back(mk(1'b1, 1'b0, 6'd24, 48'hABCD_EF00_0000));
        out_ready = 1'b0;
        req1_valid = 1'b1; req1_data = 48'h8000_0000_0000; step();
        req1_data = 48'h0000_0000_0002; step();
        req1_data = 48'h0001_0000_0000; step();
        req1_data = 48'h0F00_0000_0003;
        #1 chk("t4_ready_d", req1_ready, 1);
        step();
        req1_valid = 1'b0; step();
        out_ready = 1'b1; step();
        out_ready = 1'b0; req1_valid = 1'b1; req1_data = 48'h0000_00AB_CDEF;
        #1 chk("t4_cnt3_ready", req1_ready, 1);
        step();
        #1 chk("t4_cnt4_ready", req1_ready, 0);
        step();
        req1_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        chk("t4_sb_empty", exp_q.size(), 0);

        // Reset with three samples in flight
        do_reset();
        out_ready = 1'b0; req0_data = 48'h0000_0000_FFFF;
        for (int j = 0; j < 3; j++) begin
            req0_valid = 1'b1;
            #1 chk("t5_ready0", req0_ready, 1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        #1 chk("t5_valid_pre", out_valid, 1);
        req1_valid = 1'b1; req1_data = 48'h0000_0000_0100;
        reset_n = 1'b0;
        #1;
        chk("t5_valid_rst", out_valid, 0);
        chk("t5_ready1_rst", req1_ready, 0);
        chk("t5_lzd_din_rst", lzd_din, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("t5_ready1", req1_ready, 1);
        chk("t5_valid_rel", out_valid, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("t5_lzd_din", lzd_din, 48'h0000_0000_0100);
        chk("t5_valid_k", out_valid, 0);
        @(posedge clk); #1;
        chk("t5_valid_k1", out_valid, 0);
        @(posedge clk); #1;
        chk("t5_valid_k2", out_valid, 1);
        chk("t5_tag",  out_tag, 1);
        chk("t5_numz", out_numz, 39);
        chk("t5_mant", out_mant, 48'h8000_0000_0000);
        chk("t5_zero", out_zero, 0);

        // Random traffic against the scoreboard
        do_reset();
        auto_exp = 1'b1;
        hs_count = 0;
        cyc = 0;
        while (hs_count < 10000 && cyc < 60000) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_data  = rnd_sample();
            req1_data  = rnd_sample();
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        chk("rand_budget", {63'b0, cyc < 60000}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        chk("rand_sb_empty", exp_q.size(), 0);
        chk("rand_out_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzd_norm_arb.md
# lzd_norm_arb

Two-requester arbiter and sequencer for the shared 48-bit leading-zero detector in the RNG normalisation datapath. It accepts raw 48-bit uniform samples from two producers over valid/ready, grants the single LZD round-robin, and aligns each sample with its registered zero count. It left-normalises the sample and returns the result through a 4-entry output FIFO, tagged with the requester id. Sits between the uniform generators (log path = requester 0, sqrt/trig path = requester 1) and the downstream log/sqrt evaluators.

## Interface

- No parameters; widths fixed: data 48, count 6, FIFO depth 4.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- scan_in0, scan_en, test_mode  in  1  scan hooks, functionally unused
- scan_out0  out  1  tied 0 until scan insertion
- req0_valid, req1_valid  in  1  request present
- req0_data, req1_data  in  48  sample to normalise
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready
- lzd_din  out  48  to LZD din, driven from the issue register
- lzd_numz  in  6  from LZD numz, registered 1 cycle after lzd_din; 48 for zero input
- lzd_reset  out  1  equals ~reset_n (LZD reset is active-high)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_tag  out  1  requester id of head
- out_numz  out  6  leading-zero count, 0..48
- out_mant  out  48  req_data << numz, low bits zero-filled
- out_zero  out  1  input was all zeros (numz==48, mant==0)

## Operation

- Pipeline:
  - S1 issue register: data, tag, v1.
  - S2 align register: data, tag, v2; lzd_numz belongs to S2.
  - Normalise: combinational barrel shift of S2 data by lzd_numz.
  - 4-entry FIFO: {tag, zero, numz, mant}.
- Stages advance every cycle; S1/S2 never stall. Flow control is by credit only.
- Credit: accept a request only if fifo_count + v1 + v2 < 4. FIFO writes therefore never overflow and ready never depends on out_ready combinationally.
- Arbitration, when credit is available:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last.
  - last_grant updates only on an actual grant.
  - At most one grant per cycle. Readies are one-hot or zero.
- readyN = credit_ok & grant_to_N. Data is captured into S1 on the same edge.
- No grant: v1 loads 0; S1 data holds its value, so lzd_din is stable.
- Mid-cycle deassert of valid without handshake is allowed. Arbitration re-evaluates every cycle.
- FIFO is 2-bit pointers plus a 3-bit count.
  - Simultaneous push and pop: count unchanged.
  - Pop when empty: ignored, because out_valid is 0.
- Zero input: numz 48, shift result 0, out_zero 1.
- numz values 49..63 from the LZD are illegal. Flag with an assertion; force mant to 0 and zero to 1.

## Timing

- Reset (async assert, sync release):
  - v1, v2 = 0; S1/S2 data = 0; lzd_din = 0.
  - FIFO empty; out_valid 0; out_tag, out_numz, out_mant, out_zero = 0.
  - last_grant = 1, so req0 wins the first tie.
  - req0_ready, req1_ready = 0 while reset_n low.
- Latency: handshake at edge k enters S1; k+1 enters S2 with numz; k+2 written to FIFO. out_valid is high in the cycle after edge k+2 if the FIFO was empty (3 cycles).
- Throughput: 1 result per cycle when out_ready is held high.
- With out_ready low: at most 4 requests are accepted, then both readies stay 0 until a pop. Ready recovers in the cycle after the pop edge.
- Reset mid-operation: all in-flight and queued results are discarded. No out_valid until new requests complete the full latency.
- Outputs are FIFO-head registers, stable while out_valid & ~out_ready.

## Test plan

- Single req0, data 48'h0000_0000_0001, out_ready=1 -> out_valid 3 cycles after handshake; tag 0, numz 47, mant 48'h8000_0000_0000, zero 0.
- req0 data 0 and req1 data 48'hFFFF_FFFF_FFFF both valid continuously -> grants alternate 0,1,0,1 starting with 0; outputs in grant order, numz 48/zero 1 for tag 0 and numz 0 for tag 1.
- out_ready=0, both requesters valid -> exactly 4 handshakes, then both readies 0; raise out_ready -> 4 results drain in order, new grants resume.
- Simultaneous push and pop at count 4 is prevented by credit; check count 3 with push+pop -> count stays 3, no data loss (scoreboard).
- reset_n low for 1 cycle with 3 items in flight -> out_valid 0 immediately, FIFO empty, next req1 result has correct numz after 3 cycles.
- Random 10k samples, random valids and out_ready -> scoreboard matches reference count/shift, no duplicates or drops, per-requester order preserved.
